tx_ds_char: RTL and testbench

Serializer for one SpaceWire-style character on the transmit path: it accepts a normal (8-bit data) or link/control (2-bit) character and emits it one bit per `TxClk`. The sequence is parity, control flag, then data LSB-first. Each bit appears as a one-hot strobe pair (`Tx1` for a 1, `Tx0` for a 0), which the downstream Data/Strobe encoder converts to line toggles. The block keeps the running odd parity across characters.

---
 rtl/tx_ds_char_pkg.sv | 22 ++
 rtl/tx_ds_char_shift.sv | 46 ++++
 rtl/tx_ds_char.sv | 139 +++++++++++++
 tb/tb_tx_ds_char.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/tx_ds_char_pkg.sv
// Shared types and constants for the transmit character serializer.
// Optional simulation checks in the top are enabled by TX_DS_CHAR_CHECKS_EN.
package tx_ds_char_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PAR  = 3'd2,
    FLAG = 3'd3,
    DATA = 3'd4
  } state_e;

  localparam int NCHAR_DBITS = 8;
  localparam int LCHAR_DBITS = 2;
  localparam int CNT_W       = 4;

  // Data-bit parity of a character: lchars carry only two data bits.
  function automatic logic char_parity(input logic [7:0] dat, input logic lchar);
    char_parity = lchar ? ^dat[1:0] : ^dat;
  endfunction

endpackage

// File: rtl/tx_ds_char_shift.sv
// LSB-first character shift register with a count of data bits still to emit.
// last_o: bit_o is the final data bit; empty_o: every data bit has been emitted.
module tx_ds_char_shift
  import tx_ds_char_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       shift_i,
  input  logic       lchar_i,
  input  logic [7:0] dat_i,
  output logic       bit_o,
  output logic       last_o,
  output logic       empty_o
);

  logic [7:0]       sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sh_d  = dat_i;
      cnt_d = lchar_i ? CNT_W'(LCHAR_DBITS) : CNT_W'(NCHAR_DBITS);
    end else if (shift_i) begin
      sh_d  = {1'b0, sh_q[7:1]};
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign bit_o   = sh_q[0];
  assign last_o  = (cnt_q == CNT_W'(1));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/tx_ds_char.sv
// Serializes one normal or link/control character as parity, flag, then data LSB-first onto Tx1/Tx0 strobes.
// Keeps running odd parity across characters; TX_DS_CHAR_CHECKS_EN adds simulation-only protocol checks.
module tx_ds_char
  import tx_ds_char_pkg::*;
(
  input  logic       TxClk,
  input  logic       TxReset,
  input  logic       valid_i,
  input  logic [7:0] dat_i,
  input  logic       lchar_i,
  output logic       Tx0,
  output logic       Tx1,
  output logic       ready_o
);

  state_e state_q, state_d;
  logic   tx0_q, tx0_d;
  logic   tx1_q, tx1_d;
  logic   ready_q, ready_d;
  logic   prev_par_q, prev_par_d;
  logic   lchar_q, lchar_d;
  logic   char_par_q, char_par_d;

  logic   accept;
  logic   load;
  logic   shift;
  logic   sh_bit;
  logic   sh_last;
  logic   sh_empty;

  assign accept = valid_i && ready_q;

  tx_ds_char_shift u_shift (
    .clk     (TxClk),
    .rst     (TxReset),
    .load_i  (load),
    .shift_i (shift),
    .lchar_i (lchar_i),
    .dat_i   (dat_i),
    .bit_o   (sh_bit),
    .last_o  (sh_last),
    .empty_o (sh_empty)
  );

  // Registered outputs describe the state being entered, so each case emits the next bit.
  always_comb begin
    state_d    = state_q;
    tx0_d      = 1'b0;
    tx1_d      = 1'b0;
    prev_par_d = prev_par_q;
    lchar_d    = lchar_q;
    char_par_d = char_par_q;
    load       = 1'b0;
    shift      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = LOAD;
          load    = 1'b1;
        end
      end
      LOAD: begin
        state_d = PAR;
        tx1_d   = ~(prev_par_q ^ lchar_q);
        tx0_d   = prev_par_q ^ lchar_q;
      end
      PAR: begin
        state_d = FLAG;
        tx1_d   = lchar_q;
        tx0_d   = ~lchar_q;
      end
      FLAG: begin
        state_d = DATA;
        shift   = 1'b1;
        tx1_d   = sh_bit;
        tx0_d   = ~sh_bit;
      end
      DATA: begin
        if (sh_empty) begin
          prev_par_d = char_par_q;
          if (accept) begin
            state_d = LOAD;
            load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          shift = 1'b1;
          tx1_d = sh_bit;
          tx0_d = ~sh_bit;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      lchar_d    = lchar_i;
      char_par_d = char_parity(dat_i, lchar_i);
    end
    ready_d = ((state_d == IDLE) || (shift && sh_last)) && !valid_i;
  end

  always_ff @(posedge TxClk) begin
    if (TxReset) begin
      state_q    <= IDLE;
      tx0_q      <= 1'b0;
      tx1_q      <= 1'b0;
      ready_q    <= 1'b1;
      prev_par_q <= 1'b0;
      lchar_q    <= 1'b0;
      char_par_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx0_q      <= tx0_d;
      tx1_q      <= tx1_d;
      ready_q    <= ready_d;
      prev_par_q <= prev_par_d;
      lchar_q    <= lchar_d;
      char_par_q <= char_par_d;
    end
  end

  assign Tx0     = tx0_q;
  assign Tx1     = tx1_q;
  assign ready_o = ready_q;

`ifdef TX_DS_CHAR_CHECKS_EN
  always @(posedge TxClk) begin
    if (!TxReset) begin
      if (Tx0 && Tx1)
        $error("tx_ds_char: Tx0 and Tx1 both high");
      if (valid_i && !ready_o)
        $warning("tx_ds_char: valid_i while ready_o low, character dropped");
    end
  end
`else
  // Checks compiled out; datapath is unaffected.
`endif

endmodule

// File: tb/tb_tx_ds_char.sv
// Directed bench for tx_ds_char; expected strobes per cycle are packed as {ready_o, Tx1, Tx0}.
module tb_tx_ds_char;

  logic       TxClk = 1'b0;
  logic       TxReset;
  logic       valid_i;
  logic [7:0] dat_i;
  logic       lchar_i;
  logic       Tx0;
  logic       Tx1;
  logic       ready_o;

  int total = 0;
  int bad   = 0;

  tx_ds_char dut (
    .TxClk   (TxClk),
    .TxReset (TxReset),
    .valid_i (valid_i),
    .dat_i   (dat_i),
    .lchar_i (lchar_i),
    .Tx0     (Tx0),
    .Tx1     (Tx1),
    .ready_o (ready_o)
  );

  always #5 TxClk = ~TxClk;

  // Apply inputs for one edge, then settle 1 time unit past it.
  task automatic drive(input logic v, input logic l, input logic [7:0] d, input logic r);
    valid_i = v;
    lchar_i = l;
    dat_i   = d;
    TxReset = r;
    @(posedge TxClk);
    #1;
    valid_i = 1'b0;
    TxReset = 1'b0;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      total++;
      if ({ready_o, Tx1, Tx0} !== 3'b100) begin
        bad++;
        $display("FAIL reset[%0d] got=%b exp=100", i, {ready_o, Tx1, Tx0});
      end
    end
  endtask

  task automatic test_normal();
    logic [2:0]  exp [13] = '{3'b000, 3'b010, 3'b001, 3'b001, 3'b010, 3'b001, 3'b010,
                              3'b001, 3'b010, 3'b001, 3'b110, 3'b100, 3'b100};
    logic [12:0] vld = 13'h0001;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      drive(vld[i], 1'b0, 8'hAA, 1'b0);
      total++;
      if ({ready_o, Tx1, Tx0} !== exp[i]) begin
        bad++;
        $display("FAIL normal[%0d] got=%b exp=%b", i, {ready_o, Tx1, Tx0}, exp[i]);
      end
    end
  endtask

  // Reset at D1, then an lchar 0x00 whose parity shows prev_par was cleared.
  task automatic test_lchar_reset();
    logic [2:0]  exp [12] = '{3'b000, 3'b001, 3'b010, 3'b001, 3'b110, 3'b100,
                              3'b000, 3'b001, 3'b010, 3'b001, 3'b101, 3'b100};
    logic [11:0] vld = 12'h041;
    logic [11:0] rst = 12'h020;
    logic [7:0]  d;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      d = (i < 6) ? 8'hAA : 8'h00;
      drive(vld[i], 1'b1, d, rst[i]);
      total++;
      if ({ready_o, Tx1, Tx0} !== exp[i]) begin
        bad++;
        $display("FAIL lchar_reset[%0d] got=%b exp=%b", i, {ready_o, Tx1, Tx0}, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] exp [4] = '{3'b000, 3'b010, 3'b100, 3'b100};
    logic [3:0] vld = 4'h1;
    logic [3:0] rst = 4'h4;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(vld[i], 1'b0, 8'hFF, rst[i]);
      total++;
      if ({ready_o, Tx1, Tx0} !== exp[i]) begin
        bad++;
        $display("FAIL reset_mid[%0d] got=%b exp=%b", i, {ready_o, Tx1, Tx0}, exp[i]);
      end
    end
  endtask

  task automatic test_drop();
    logic [2:0]  exp [13] = '{3'b000, 3'b010, 3'b001, 3'b001, 3'b010, 3'b001, 3'b010,
                              3'b001, 3'b010, 3'b001, 3'b110, 3'b100, 3'b100};
    logic [12:0] vld = 13'h0089;
    logic [7:0]  d;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      d = (i == 0) ? 8'hAA : 8'h55;
      drive(vld[i], 1'b0, d, 1'b0);
      total++;
      if ({ready_o, Tx1, Tx0} !== exp[i]) begin
        bad++;
        $display("FAIL drop[%0d] got=%b exp=%b", i, {ready_o, Tx1, Tx0}, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  exp [11] = '{3'b000, 3'b001, 3'b010, 3'b001, 3'b110, 3'b000,
                              3'b010, 3'b010, 3'b001, 3'b101, 3'b100};
    logic [10:0] vld = 11'h021;
    logic [7:0]  d;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      d = (i < 5) ? 8'h02 : 8'h00;
      drive(vld[i], 1'b1, d, 1'b0);
      total++;
      if ({ready_o, Tx1, Tx0} !== exp[i]) begin
        bad++;
        $display("FAIL back_to_back[%0d] got=%b exp=%b", i, {ready_o, Tx1, Tx0}, exp[i]);
      end
    end
  endtask

  task automatic test_valid_at_d0();
    logic [2:0] exp [7] = '{3'b000, 3'b001, 3'b010, 3'b001, 3'b010, 3'b100, 3'b100};
    logic [6:0] vld = 7'h11;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(vld[i], 1'b1, 8'hAA, 1'b0);
      total++;
      if ({ready_o, Tx1, Tx0} !== exp[i]) begin
        bad++;
        $display("FAIL valid_at_d0[%0d] got=%b exp=%b", i, {ready_o, Tx1, Tx0}, exp[i]);
      end
    end
  endtask

  initial begin
    TxReset = 1'b1;
    valid_i = 1'b0;
    lchar_i = 1'b0;
    dat_i   = 8'h00;
    test_reset();
    test_normal();
    test_lchar_reset();
    test_reset_mid();
    test_drop();
    test_back_to_back();
    test_valid_at_d0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
